// File: rtl/hazard_unit.sv
// hazard_unit: load-use / RAW stall, taken-branch squash and ALU forwarding
// control for a 5-stage IF/ID/EX/MEM/WB pipeline, with saturating stall and
// flush statistics.
//
// Build option: define HAZARD_FWD_EN to enable operand forwarding. With it,
// only a load followed directly by a consumer stalls (one cycle). Without it,
// forwarding selects stay at 00 and any pending valid writer of a source
// register in EX, MEM or WB stalls the ID instruction, for up to three cycles.
//
// All hazard, flush and forwarding outputs are combinational from the current
// inputs and the shadow valid bits. rst is synchronous and active-low.
module hazard_unit #(
    parameter int REG_W  = 5,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  ex_rs,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              ex_memrd,
    input  logic              ex_regwr,
    input  logic [REG_W-1:0]  ex_dst,
    input  logic              me_regwr,
    input  logic [REG_W-1:0]  me_dst,
    input  logic              wb_regwr,
    input  logic [REG_W-1:0]  wb_dst,
    input  logic              br_taken,
    output logic              pc_wr_en,
    output logic              ifid_wr_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exme_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    // STALL only records that the previous cycle was stalled; it never gates
    // any output.
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Shadow valids: the datapath control of a squashed or bubbled stage may
    // still carry stale RegWrite/destination bits, so writers are qualified
    // with these.
    logic v_ex_reg, v_me_reg, v_wb_reg;

    logic [STAT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    // Writer table, index 0 = EX, 1 = MEM, 2 = WB.
    logic [REG_W-1:0] wr_dst [3];
    logic [2:0]       wr_ok;
    logic [2:0]       wr_hit;

    logic             hazard;
    logic             stall;
    logic [1:0]       fwd_sel [2];

    assign wr_dst[0] = ex_dst;
    assign wr_dst[1] = me_dst;
    assign wr_dst[2] = wb_dst;

    // Register 0 is hard-wired, so a writer targeting it is never a producer.
    assign wr_ok[0] = ex_regwr & v_ex_reg & (ex_dst != '0);
    assign wr_ok[1] = me_regwr & v_me_reg & (me_dst != '0);
    assign wr_ok[2] = wb_regwr & v_wb_reg & (wb_dst != '0);

    genvar gi;

    // A writer hits when the real ID instruction reads its destination.
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hit
            assign wr_hit[gi] = id_valid & wr_ok[gi] &
                                ((wr_dst[gi] == id_rs) |
                                 (id_uses_rt & (wr_dst[gi] == id_rt)));
        end
    endgenerate

`ifdef HAZARD_FWD_EN
    // Forwarding covers ALU producers; only a load in EX cannot be bypassed
    // in time, and the bubble it causes clears v_ex, so it lasts one cycle.
    logic [REG_W-1:0] fwd_src [2];
    logic             unused_hit;

    assign fwd_src[0] = ex_rs;
    assign fwd_src[1] = ex_rt;
    assign hazard     = ex_memrd & wr_hit[0];
    assign unused_hit = ^wr_hit[2:1];

    // MEM holds the younger result, so it wins over WB for the same register.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = (wr_ok[1] & (me_dst == fwd_src[gi])) ? 2'b10 :
                                 (wr_ok[2] & (wb_dst == fwd_src[gi])) ? 2'b01 :
                                                                        2'b00;
        end
    endgenerate
`else
    // No bypass and the register file is not write-through: wait until the
    // producer has fully left WB.
    logic unused_fwd;

    assign hazard     = |wr_hit;
    assign fwd_sel[0] = 2'b00;
    assign fwd_sel[1] = 2'b00;
    assign unused_fwd = ^{ex_rs, ex_rt, ex_memrd};
`endif

    // A taken branch squashes the stalled instruction anyway, so it wins.
    assign stall = rst & ~br_taken & hazard;

    // Pipeline control and forwarding outputs; reset forces free-running defaults.
    always_comb begin
        pc_wr_en    = 1'b1;
        ifid_wr_en  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exme_flush  = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (rst) begin
            fwd_a = fwd_sel[0];
            fwd_b = fwd_sel[1];
            if (br_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exme_flush  = 1'b1;
            end else if (stall) begin
                pc_wr_en    = 1'b0;
                ifid_wr_en  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // Next-state logic: track whether the pipeline is currently held.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (stall) state_next = STALL;
            STALL:   state_next = stall ? STALL : RUN;
            default: state_next = RUN;
        endcase
        if (br_taken) state_next = RUN;
    end

    // State, shadow valids and saturating statistics.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= RUN;
            v_ex_reg      <= 1'b0;
            v_me_reg      <= 1'b0;
            v_wb_reg      <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            v_ex_reg  <= id_valid & ~stall & ~br_taken;
            v_me_reg  <= v_ex_reg & ~br_taken;
            v_wb_reg  <= v_me_reg;
            if (stall && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (br_taken && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule
